// File: rtl/xy_input_port_pkg.sv
// -----------------------------------------------------------------------------
// xy_input_port_pkg
// Shared types and constants for the AXI-Stream NoC router ingress stage.
//   axis_data_t / axi_packet_t : one stream beat (TDATA, TID, TDEST, TUSER, TLAST)
//   ROUTING_HEADER             : TID value marking the first beat of a packet
//   PORT_LOCAL .. PORT_WEST    : router port indices
//   hdr_field()                : extracts target_x / target_y / count from TDATA
//   in_state_e                 : ingress FSM state encoding
// -----------------------------------------------------------------------------
package xy_input_port_pkg;

   localparam int AXI_DATA_WIDTH = 32;
   localparam int AXI_ID_WIDTH   = 4;
   localparam int AXI_DEST_WIDTH = 4;
   localparam int AXI_USER_WIDTH = 4;

   typedef logic [AXI_DATA_WIDTH-1:0] axis_data_t;

   typedef struct packed {
      axis_data_t                tdata;
      logic [AXI_ID_WIDTH-1:0]   tid;
      logic [AXI_DEST_WIDTH-1:0] tdest;
      logic [AXI_USER_WIDTH-1:0] tuser;
      logic                      tlast;
   } axi_packet_t;

   localparam logic [AXI_ID_WIDTH-1:0] ROUTING_HEADER = 4'hF;

   // Router port indices
   localparam int NUM_PORTS = 5;
   typedef logic [2:0] port_idx_t;
   localparam port_idx_t PORT_LOCAL = 3'd0;
   localparam port_idx_t PORT_NORTH = 3'd1;
   localparam port_idx_t PORT_EAST  = 3'd2;
   localparam port_idx_t PORT_SOUTH = 3'd3;
   localparam port_idx_t PORT_WEST  = 3'd4;

   // Width of the payload-beat count field in the header
   localparam int HDR_COUNT_WIDTH = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } in_state_e;

   // Returns TDATA[lsb +: width] zero-extended to 8 bits (width <= 8).
   // Header layout with W = x_width + y_width:
   //   target_y = field(0, y_width), target_x = field(y_width, x_width),
   //   count    = field(2W, 8)
   function automatic logic [7:0] hdr_field(input axis_data_t d,
                                            input int unsigned lsb,
                                            input int unsigned width);
      axis_data_t sh;
      sh = d >> lsb;
      // For width 8 the shift wraps to zero, so the mask becomes 8'hFF.
      return sh[7:0] & ((8'd1 << width) - 8'd1);
   endfunction

endpackage

// File: rtl/xy_input_port_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through head (no write bypass: a word
// written in cycle t is visible at rdata from cycle t+1).
//   clk, rst_n : clock, asynchronous active-low reset
//   push, wdata: write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   rdata      : current head entry
//   full/empty : status flags
// Pointers carry one extra wrap bit to distinguish full from empty.
// -----------------------------------------------------------------------------
module sync_fifo
   import xy_input_port_pkg::*;
#(
   parameter type DATA_T = axi_packet_t,
   parameter int  DEPTH  = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  DATA_T wdata,
   input  logic  pop,
   output DATA_T rdata,
   output logic  full,
   output logic  empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   DATA_T         mem_r [DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          wr_en_s;
   logic          rd_en_s;

   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign wr_en_s = push && !full;
   assign rd_en_s = pop && !empty;
   assign rdata   = mem_r[rd_ptr_r[AW-1:0]];

   // Storage array and pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= DATA_T'(1'b0);
         end
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
            wr_ptr_r                <= wr_ptr_r + PTR_ONE;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/xy_input_port.sv
// -----------------------------------------------------------------------------
// xy_input_port
// Ingress stage of one AXI-Stream NoC router input channel. Beats are buffered
// in a small FIFO; the ROUTING_HEADER beat at the head selects an output port
// by XY routing (X first, then Y). The route is held for the header's count of
// payload beats, and the beats are offered to exactly one output arbiter.
// Non-header beats arriving outside a packet are dropped.
//   clk, rst_n          : clock, asynchronous active-low reset
//   router_x, router_y  : static coordinates of this router
//   in, in_valid        : incoming beat; in_ready = FIFO not full
//   out                 : FIFO head broadcast to every output arbiter
//   out_valid           : one-hot (or zero) request toward the output arbiters
//   out_ready           : grants from the output arbiters
//   err_count           : dropped-beat counter, saturating at 255; present only
//                         when INPUT_PORT_ERR_CNT_EN is defined
// -----------------------------------------------------------------------------
module xy_input_port
   import xy_input_port_pkg::*;
#(
   parameter int  DATA_WIDTH     = 32,
   parameter int  ID_WIDTH       = 4,
   parameter int  DEST_WIDTH     = 4,
   parameter int  USER_WIDTH     = 4,
   parameter int  CHANNEL_NUMBER = 5,
   parameter int  MAX_ROUTERS_X  = 4,
   parameter int  MAX_ROUTERS_Y  = 4,
   parameter int  BUFFER_DEPTH   = 4,
   localparam int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
   localparam int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [MAX_ROUTERS_X_WIDTH-1:0]  router_x,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0]  router_y,
   input  axi_packet_t                     in,
   input  logic                            in_valid,
   output logic                            in_ready,
   output axi_packet_t [CHANNEL_NUMBER-1:0] out,
   output logic [CHANNEL_NUMBER-1:0]       out_valid,
   input  logic [CHANNEL_NUMBER-1:0]       out_ready
`ifdef INPUT_PORT_ERR_CNT_EN
   ,
   output logic [7:0]                      err_count
`endif
);

   localparam int HDR_W = MAX_ROUTERS_X_WIDTH + MAX_ROUTERS_Y_WIDTH;

   // The packet struct comes from the package, so the widths must agree.
   if (DATA_WIDTH != AXI_DATA_WIDTH || ID_WIDTH != AXI_ID_WIDTH ||
       DEST_WIDTH != AXI_DEST_WIDTH || USER_WIDTH != AXI_USER_WIDTH ||
       CHANNEL_NUMBER != NUM_PORTS || BUFFER_DEPTH < 2 ||
       (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_cfg_err
      $error("xy_input_port: unsupported parameter combination");
   end

   axi_packet_t head_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic        push_s;
   logic        pop_s;

   in_state_e   state_r;
   in_state_e   state_next_s;
   logic [7:0]  beats_left_r;
   logic [7:0]  beats_next_s;
   port_idx_t   route_r;
   port_idx_t   route_next_s;
   port_idx_t   route_s;
   port_idx_t   sel_s;
   logic        sel_valid_s;
   logic        drop_s;

   logic [7:0]  tx_s;
   logic [7:0]  ty_s;
   logic [7:0]  cnt_s;
   logic [7:0]  rx_s;
   logic [7:0]  ry_s;

   assign in_ready = !fifo_full_s;
   assign push_s   = in_valid && !fifo_full_s;

   sync_fifo #(
      .DATA_T (axi_packet_t),
      .DEPTH  (BUFFER_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata (in),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign ty_s  = hdr_field(head_s.tdata, 0, MAX_ROUTERS_Y_WIDTH);
   assign tx_s  = hdr_field(head_s.tdata, MAX_ROUTERS_Y_WIDTH, MAX_ROUTERS_X_WIDTH);
   assign cnt_s = hdr_field(head_s.tdata, 2 * HDR_W, HDR_COUNT_WIDTH);
   assign rx_s  = 8'(router_x);
   assign ry_s  = 8'(router_y);

   // XY route of the head beat: resolve X first, then Y
   always_comb begin
      route_s = PORT_LOCAL;
      if (tx_s > rx_s) begin
         route_s = PORT_EAST;
      end else if (tx_s < rx_s) begin
         route_s = PORT_WEST;
      end else if (ty_s > ry_s) begin
         route_s = PORT_NORTH;
      end else if (ty_s < ry_s) begin
         route_s = PORT_SOUTH;
      end else begin
         route_s = PORT_LOCAL;
      end
   end

   // Packet FSM: port selection, drop decision and next-state/counter values
   always_comb begin
      state_next_s = state_r;
      beats_next_s = beats_left_r;
      route_next_s = route_r;
      sel_s        = route_r;
      sel_valid_s  = 1'b0;
      drop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               if (head_s.tid == ROUTING_HEADER) begin
                  sel_s       = route_s;
                  sel_valid_s = 1'b1;
                  if (out_ready[route_s]) begin
                     route_next_s = route_s;
                     beats_next_s = cnt_s;
                     // A zero count is a header-only packet.
                     state_next_s = (cnt_s != 8'd0) ? ST_BODY : ST_IDLE;
                  end else begin
                     state_next_s = ST_IDLE;
                  end
               end else begin
                  // Stray beat outside a packet: discard without a request.
                  drop_s = 1'b1;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BODY: begin
            // The counter, not the TID, decides where the packet ends.
            sel_s       = route_r;
            sel_valid_s = !fifo_empty_s;
            if (!fifo_empty_s && out_ready[route_r]) begin
               beats_next_s = beats_left_r - 8'd1;
               state_next_s = (beats_left_r == 8'd1) ? ST_IDLE : ST_BODY;
            end else begin
               state_next_s = ST_BODY;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            beats_next_s = 8'd0;
         end
      endcase
   end

   assign pop_s = drop_s || (sel_valid_s && out_ready[sel_s]);

   // Output request decode and head broadcast
   always_comb begin
      out_valid = {CHANNEL_NUMBER{1'b0}};
      if (sel_valid_s) begin
         out_valid[sel_s] = 1'b1;
      end else begin
         out_valid = {CHANNEL_NUMBER{1'b0}};
      end
      for (int p = 0; p < CHANNEL_NUMBER; p++) begin
         out[p] = head_s;
      end
   end

   // FSM state, held route and remaining beat count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         beats_left_r <= 8'd0;
         route_r      <= PORT_LOCAL;
      end else begin
         state_r      <= state_next_s;
         beats_left_r <= beats_next_s;
         route_r      <= route_next_s;
      end
   end

`ifdef INPUT_PORT_ERR_CNT_EN
   logic [7:0] err_count_r;

   // Saturating count of dropped beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_r <= 8'd0;
      end else if (drop_s && (err_count_r != 8'hFF)) begin
         err_count_r <= err_count_r + 8'd1;
      end else begin
         err_count_r <= err_count_r;
      end
   end

   assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_xy_input_port.sv
// -----------------------------------------------------------------------------
// tb_xy_input_port
// Bench for xy_input_port with the router placed at (1,1) in a 4x4 mesh.
// Accepted input beats are run through a packet-level reference model that
// queues the expected (port, beat) pairs; a monitor pops the queue whenever a
// beat is handed to an output arbiter.
// -----------------------------------------------------------------------------
module tb_xy_input_port;
   import xy_input_port_pkg::*;

   localparam int CH = 5;
   localparam int RX = 1;
   localparam int RY = 1;

   logic                     clk;
   logic                     rst_n;
   logic [1:0]               router_x;
   logic [1:0]               router_y;
   axi_packet_t              in_pkt;
   logic                     in_valid;
   logic                     in_ready;
   axi_packet_t [CH-1:0]     out_pkt;
   logic [CH-1:0]            out_valid;
   logic [CH-1:0]            out_ready;
`ifdef INPUT_PORT_ERR_CNT_EN
   logic [7:0]               err_count;
`endif

   xy_input_port dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .router_x  (router_x),
      .router_y  (router_y),
      .in        (in_pkt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out_pkt),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef INPUT_PORT_ERR_CNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          port;
      axi_packet_t beat;
   } exp_t;

   exp_t sb[$];
   int   model_rem  = 0;
   int   model_port = 0;
   int   model_err  = 0;
   int   ready_mode = 0;   // 0 all ready, 1 random, 2 none ready

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // XY routing from coordinates: X first, then Y
   function automatic int ref_route(input axi_packet_t b);
      int tx;
      int ty;
      tx = int'((b.tdata >> 2) & 32'd3);
      ty = int'(b.tdata & 32'd3);
      if (tx > RX) return 2;
      if (tx < RX) return 4;
      if (ty > RY) return 1;
      if (ty < RY) return 3;
      return 0;
   endfunction

   // Packet-level model: a header opens a packet of N payload beats
   task automatic model_accept(input axi_packet_t b);
      if (model_rem == 0) begin
         if (b.tid == ROUTING_HEADER) begin
            model_port = ref_route(b);
            sb.push_back('{model_port, b});
            model_rem = int'((b.tdata >> 8) & 32'hFF);
         end else begin
            model_err = (model_err < 255) ? model_err + 1 : 255;
         end
      end else begin
         sb.push_back('{model_port, b});
         model_rem--;
      end
   endtask

   function automatic axi_packet_t mk(input logic [3:0] tid, input logic [31:0] data);
      axi_packet_t b;
      b       = '0;
      b.tid   = tid;
      b.tdata = data;
      b.tdest = 4'($urandom);
      b.tuser = 4'($urandom);
      b.tlast = 1'($urandom);
      return b;
   endfunction

   // Offer one beat; starts and ends 1 time unit after a rising edge
   task automatic send(input axi_packet_t b);
      bit ok;
      ok       = 1'b0;
      in_pkt   = b;
      in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(b);
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Output-ready driver
   initial begin
      out_ready = '1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = '1;
            1:       out_ready = 5'($urandom);
            default: out_ready = '0;
         endcase
      end
   end

   // Monitor: one-hot request, stall stability and scoreboard comparison
   initial begin : mon
      exp_t        e;
      bit          have_prev;
      int          prev_port;
      axi_packet_t prev_beat;
      have_prev = 1'b0;
      prev_port = 0;
      prev_beat = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            have_prev = 1'b0;
            continue;
         end
         chk("onehot", 64'($countones(out_valid) <= 1), 64'd1);
         if (have_prev) begin
            chk("hold_valid", 64'(out_valid[prev_port]), 64'd1);
            chk("hold_data", 64'(out_pkt[prev_port]), 64'(prev_beat));
         end
         have_prev = 1'b0;
         for (int p = 0; p < CH; p++) begin
            if (out_valid[p]) begin
               if (out_ready[p]) begin
                  if (sb.size() == 0) begin
                     chk("unexpected_beat", 64'(p), 64'hFF);
                  end else begin
                     e = sb.pop_front();
                     chk("port", 64'(p), 64'(e.port));
                     chk("beat", 64'(out_pkt[p]), 64'(e.beat));
                  end
               end else begin
                  have_prev = 1'b1;
                  prev_port = p;
                  prev_beat = out_pkt[p];
               end
            end
         end
      end
   end

   initial begin
      router_x = 2'd1;
      router_y = 2'd1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_pkt   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef INPUT_PORT_ERR_CNT_EN
      chk("rst_err_count", 64'(err_count), 64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // East packet: header (3,1) N=2 plus two payload beats
      ready_mode = 0;
      send(mk(ROUTING_HEADER, 32'h0000_020D));
      send(mk(4'h0, 32'hA5A5_0001));
      send(mk(4'h1, 32'hA5A5_0002));
      wait_drain();

      // Header-only packets: LOCAL, then a fresh route to WEST
      send(mk(ROUTING_HEADER, 32'h0000_0005));
      send(mk(ROUTING_HEADER, 32'h0000_0001));
      wait_drain();

      // Back-pressure: fill the FIFO toward NORTH, then release
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(mk(ROUTING_HEADER, 32'h0000_0307));
      send(mk(4'h2, 32'h1111_0001));
      send(mk(ROUTING_HEADER, 32'h1111_0002));
      send(mk(4'h3, 32'h1111_0003));
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_out_valid", 64'(out_valid), 64'b00010);
      @(posedge clk);
      #1;
      ready_mode = 0;
      wait_drain();

      // Stray non-header beat in IDLE is dropped, then a header still passes
      send(mk(4'h3, 32'h0000_1234));
      repeat (3) @(posedge clk);
      #1;
`ifdef INPUT_PORT_ERR_CNT_EN
      chk("err_count_drop", 64'(err_count), 64'(model_err));
`endif
      send(mk(ROUTING_HEADER, 32'h0000_000D));
      wait_drain();

      // Reset after one of three payload beats
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(mk(ROUTING_HEADER, 32'h0000_030D));
      send(mk(4'h0, 32'h2222_0001));
      @(negedge clk);
      chk("pre_rst_valid", 64'(out_valid), 64'b00100);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      model_rem = 0;
      model_err = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      ready_mode = 0;
      @(posedge clk);
      #1;
      send(mk(ROUTING_HEADER, 32'h0000_0001));
      wait_drain();

      // Random traffic with random back-pressure
      ready_mode = 1;
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(4) == 0) begin
            send(mk(4'($urandom_range(14)), $urandom));
         end else begin
            int n;
            logic [31:0] d;
            n = $urandom_range(4);
            d = $urandom;
            d[15:8] = 8'(n);
            send(mk(ROUTING_HEADER, d));
            for (int j = 0; j < n; j++) begin
               send(mk(4'($urandom), $urandom));
            end
         end
      end
      ready_mode = 0;
      wait_drain();
`ifdef INPUT_PORT_ERR_CNT_EN
      chk("err_count_final", 64'(err_count), 64'(model_err));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xy_input_port.md
Name: xy_input_port

Overview:
- Per-input-port ingress stage of the AXI-Stream NoC router; one instance per router input channel.
- Buffers incoming beats in a small FIFO and computes the XY route from the ROUTING_HEADER beat.
- Holds that route for the whole packet and presents the beats to exactly one output-side arbiter, driving that arbiter's in/in_valid and taking its in_ready.
- The packet length count in the header is authoritative; this block keeps the same beat accounting as the downstream arbiter.

Parameters:
DATA_WIDTH, 32, TDATA width
ID_WIDTH, 4, TID width
DEST_WIDTH, 4, TDEST width
USER_WIDTH, 4, TUSER width
CHANNEL_NUMBER, 5, number of router ports (0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST)
MAX_ROUTERS_X, 4, mesh width; MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X)
MAX_ROUTERS_Y, 4, mesh height; MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
BUFFER_DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock; single clock domain
rst_n  in  1  asynchronous active-low reset
router_x  in  MAX_ROUTERS_X_WIDTH  this router's X coordinate; static
router_y  in  MAX_ROUTERS_Y_WIDTH  this router's Y coordinate; static
in  in  axi_packet_t  incoming beat
in_valid  in  1  beat valid
in_ready  out  1  beat accepted
out  out  axi_packet_t [CHANNEL_NUMBER]  FIFO head, broadcast to every port
out_valid  out  1 [CHANNEL_NUMBER]  valid toward each output arbiter; at most one set
out_ready  in  1 [CHANNEL_NUMBER]  ready from each output arbiter

Behaviour:
- Reset:
  - FIFO empty; FSM in IDLE; beats_left = 0; route_reg = 0.
  - All out_valid = 0.
  - in_ready = 1 (it is !full, and the FIFO is empty).
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full; no push-through when full.
  - A beat pushed in cycle t appears at the head in cycle t+1; there is no bypass.
  - Simultaneous push and pop is legal when not full; occupancy is unchanged.
  - Pointers are BUFFER_DEPTH-wrapping, with an extra wrap bit for full/empty.
- Header fields. Let W = MAX_ROUTERS_X_WIDTH + MAX_ROUTERS_Y_WIDTH.
  - target_y = TDATA[MAX_ROUTERS_Y_WIDTH-1:0]
  - target_x = TDATA[W-1:MAX_ROUTERS_Y_WIDTH]
  - count N = TDATA[2W+7:2W] = number of payload beats after the header
- Route function (combinational, from head):
  - tx > router_x → EAST
  - tx < router_x → WEST
  - else ty > router_y → NORTH
  - else ty < router_y → SOUTH
  - else LOCAL
- FSM state IDLE, head valid, head.TID == ROUTING_HEADER:
  - out_valid[route(head)] = 1 in the same cycle.
  - On pop: route_reg <= route(head), beats_left <= N.
  - N != 0 → BODY; N == 0 → stay IDLE (header-only packet).
- FSM state IDLE, head valid, TID != ROUTING_HEADER:
  - Beat is dropped: popped in one cycle with no out_valid asserted.
- FSM state BODY:
  - out_valid[route_reg] = !empty.
  - Each pop decrements beats_left.
  - A pop with beats_left == 1 → IDLE.
  - A head with TID == ROUTING_HEADER in BODY is forwarded as payload; the counter governs.
- Pop condition: out_valid[sel] && out_ready[sel].
  - out_ready of non-selected ports is ignored.
  - out_valid, once asserted, holds with stable out until the pop.
- Reset mid-packet: state, counter and FIFO are cleared; partial packets are lost.
- beats_left is 8 bits; there is no wrap.

Optional Feature:
- Macro INPUT_PORT_ERR_CNT_EN.
- When defined:
  - Adds output err_count [7:0], reset to 0.
  - Increments on each dropped non-header beat in IDLE and saturates at 255.
- When undefined:
  - No port and no counter.
  - Drop behaviour is identical.

Decomposition:
- Shared package already holds axi_packet_t/axis_data_t and ROUTING_HEADER.
- Add to it:
  - Port index constants PORT_LOCAL..PORT_WEST.
  - A header field-offset function or localparams for target_x/target_y/count.
- One sub-module: sync_fifo (DATA = axi_packet_t, DEPTH = BUFFER_DEPTH) with push/pop/full/empty.
- Route compute and the FSM stay in xy_input_port.

Test Plan (router at (1,1), both widths 2, so count at TDATA[15:8]):
- Header TDATA = 0x020D (x=3, y=1, N=2) + 2 payload beats, out_ready all 1 → header plus both payload beats appear only on out_valid[2] (EAST) on consecutive cycles; then IDLE.
- Header TDATA = 0x0005 (x=1, y=1, N=0) → one beat on out_valid[0] (LOCAL); state stays IDLE; next header is routed fresh.
- Header to (1,3) with N=3, out_ready[1] held 0 while 4 beats are pushed (depth 4) → in_ready = 0 once full; releasing ready drains 4 beats on NORTH in order, no loss or duplication.
- Non-header beat while IDLE → popped in one cycle, no out_valid asserted; err_count = 1 when INPUT_PORT_ERR_CNT_EN is defined.
- rst_n pulsed low after 1 of 3 payload beats → all out_valid = 0 immediately; FIFO empty; next header routes correctly.
